// File: rtl/embedded_computer_system_pio_in.sv
// Avalon-MM parallel input port: synchronized inputs, edge capture with write-1-to-clear, masked level irq.
// Optional debounce filter compiled in with `define PIO_IN_DEBOUNCE_EN.
module embedded_computer_system_pio_in #(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int WARM_LEN = 4;
`else
  localparam int WARM_LEN = 3;
`endif

  logic [WIDTH-1:0]    sync1;
  logic [WIDTH-1:0]    sync2;
  logic [WIDTH-1:0]    level;
  logic [WIDTH-1:0]    level_d;
  logic [WIDTH-1:0]    irq_mask;
  logic [WIDTH-1:0]    edge_capture;
  logic [WIDTH-1:0]    edge_hit;
  logic [WIDTH-1:0]    clear_bits;
  logic [WARM_LEN-1:0] warm;
  logic                write_en;
  logic                detect_en;
  logic                unused_bits;

  assign write_en    = chipselect & ~write_n;
  assign unused_bits = &{1'b0, writedata};

  // Edge detection stays off until the reset-cleared pipeline has been refilled
  // from the real pins, so an input already high at reset release is not an edge.
  assign detect_en = warm[WARM_LEN-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level_d <= '0;
      warm    <= '0;
    end else begin
      sync1   <= in_port;
      sync2   <= sync1;
      level_d <= level;
      warm    <= {warm[WARM_LEN-2:0], 1'b1};
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  logic [15:0] db_cnt [WIDTH];

  // During warm-up the filter preloads from sync2 so its settled value is not seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!warm[2]) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] >= 16'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end
`else
  logic [15:0] unused_db;
  assign unused_db = 16'(DEBOUNCE_CYCLES);
  assign level     = sync2;
`endif

  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      0:       edge_hit = level & ~level_d;
      1:       edge_hit = ~level & level_d;
      default: edge_hit = level ^ level_d;
    endcase
    if (!detect_en) edge_hit = '0;
  end

  assign clear_bits = (write_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // A new edge in the same cycle as its clear wins, since the OR is applied after masking.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (write_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clear_bits) | edge_hit;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = level;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_capture;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule
